// File: rtl/mynios2_onchip_memory2_tester.sv
// Avalon-MM self-test master for the on-chip RAM: fills a word range with a seeded
// pattern or reads it back and counts mismatches against the same pattern.
module mynios2_onchip_memory2_tester #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ERRCNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       length,
    input  logic [DATA_W-1:0]     seed,
    output logic                  busy,
    output logic                  done,
    output logic [ERRCNT_W-1:0]   err_count,
    output logic [ADDR_W-1:0]     first_err_addr,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    localparam logic [DATA_W-1:0]   GOLDEN  = DATA_W'(64'h9E3779B9);
    localparam logic [ERRCNT_W-1:0] ERR_MAX = '1;

    typedef enum logic [2:0] {StIdle, StFill, StVerify, StDrain, StFinish} state_t;

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_cs;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_pat;
    logic [ADDR_W:0]     r_remain;
    logic                r_pvalid;
    logic [DATA_W-1:0]   r_pexp;
    logic [ADDR_W-1:0]   r_paddr;
    logic [ERRCNT_W-1:0] r_err;
    logic [ADDR_W-1:0]   r_first;
    logic                w_mismatch;

    // Read data arrives one cycle after the read; r_p* hold what that read expects.
    assign w_mismatch = r_pvalid && (mem_readdata != r_pexp);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StIdle;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cs     <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_pat    <= '0;
            r_remain <= '0;
            r_pvalid <= 1'b0;
            r_pexp   <= '0;
            r_paddr  <= '0;
            r_err    <= '0;
            r_first  <= '0;
        end else begin
            r_done   <= 1'b0;
            r_pvalid <= r_cs && !r_we;
            r_pexp   <= r_pat;
            r_paddr  <= r_addr;

            if (w_mismatch) begin
                if (r_err != ERR_MAX) r_err <= r_err + 1'b1;
                if (r_err == '0) r_first <= r_paddr;
            end

            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_err   <= '0;
                        r_first <= '0;
                        if (length == '0) begin
                            r_done  <= 1'b1;
                            r_state <= StFinish;
                        end else begin
                            r_busy   <= 1'b1;
                            r_cs     <= 1'b1;
                            r_we     <= !mode;
                            r_addr   <= base_addr;
                            r_pat    <= seed;
                            r_remain <= length - 1'b1;
                            r_state  <= mode ? StVerify : StFill;
                        end
                    end
                end
                StFill, StVerify: begin
                    if (r_remain == '0) begin
                        r_cs <= 1'b0;
                        r_we <= 1'b0;
                        if (r_state == StFill) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= StFinish;
                        end else begin
                            r_state <= StDrain;
                        end
                    end else begin
                        r_addr   <= r_addr + 1'b1;
                        r_pat    <= r_pat + GOLDEN;
                        r_remain <= r_remain - 1'b1;
                    end
                end
                StDrain: begin
                    // Final read's compare happens this cycle.
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= StFinish;
                end
                StFinish: r_state <= StIdle;
                default:  r_state <= StIdle;
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign err_count      = r_err;
    assign first_err_addr = r_first;
    assign mem_address    = r_addr;
    assign mem_byteenable = '1;
    assign mem_chipselect = r_cs;
    assign mem_write      = r_we;
    assign mem_writedata  = r_pat;
    assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_mynios2_onchip_memory2_tester.sv
// Bench for the RAM self-test master: behavioural RAM slave plus a pattern/error model
// computed directly from the address and pattern rules.
module tb_mynios2_onchip_memory2_tester;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int EW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int EMAX  = (1 << EW) - 1;

    logic            clk;
    logic            reset;
    logic            start;
    logic            mode;
    logic [AW-1:0]   base_addr;
    logic [AW:0]     length;
    logic [DW-1:0]   seed;
    logic            busy;
    logic            done;
    logic [EW-1:0]   err_count;
    logic [AW-1:0]   first_err_addr;
    logic [AW-1:0]   mem_address;
    logic [DW/8-1:0] mem_byteenable;
    logic            mem_chipselect;
    logic            mem_write;
    logic [DW-1:0]   mem_writedata;
    logic            mem_clken;
    logic [DW-1:0]   mem_readdata;

    logic [DW-1:0]   mem [DEPTH];
    logic            corr_req;
    logic [AW-1:0]   corr_addr;
    logic [DW-1:0]   corr_mask;

    int n_cmp  = 0;
    int n_fail = 0;

    int            lat;
    int            n_cs;
    int            busy_hi;
    logic          done_busy;
    int            q_waddr[$];
    logic [DW-1:0] q_wdata[$];
    int            q_wcyc[$];
    int            q_raddr[$];
    int            q_rcyc[$];

    mynios2_onchip_memory2_tester #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .ERRCNT_W (EW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .mode           (mode),
        .base_addr      (base_addr),
        .length         (length),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM slave: read latency 1, byte-enabled writes, cleared while reset is held.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            mem_readdata <= '0;
        end else begin
            if (corr_req) mem[corr_addr] <= mem[corr_addr] ^ corr_mask;
            if (mem_chipselect && mem_clken) begin
                if (mem_write)
                    for (int b = 0; b < DW / 8; b++)
                        if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                mem_readdata <= mem[mem_address];
            end
        end
    end

    function automatic logic [DW-1:0] pat(input logic [DW-1:0] s, input int i);
        logic [DW-1:0] k;
        logic [DW-1:0] ii;
        k  = 32'h9E3779B9;
        ii = i;
        return s + k * ii;
    endfunction

    function automatic int wa(input int b, input int i);
        return (b + i) % DEPTH;
    endfunction

    // Expected verify outcome from current RAM contents.
    task automatic model_verify(input int b, input int n, input logic [DW-1:0] s,
                                output int e, output int fa);
        e  = 0;
        fa = 0;
        for (int i = 0; i < n; i++) begin
            if (mem[wa(b, i)] !== pat(s, i)) begin
                if (e == 0) fa = wa(b, i);
                e++;
            end
        end
        if (e > EMAX) e = EMAX;
    endtask

    task automatic corrupt(input int a, input logic [DW-1:0] m);
        @(negedge clk);
        corr_req  = 1'b1;
        corr_addr = AW'(a);
        corr_mask = m;
        @(negedge clk);
        corr_req  = 1'b0;
    endtask

    // Issues one command and records bus activity until done (bounded); no checking here.
    task automatic do_run(input bit m, input int b, input int n, input logic [DW-1:0] s,
                          input int stray);
        int c;
        q_waddr.delete(); q_wdata.delete(); q_wcyc.delete();
        q_raddr.delete(); q_rcyc.delete();
        lat = -1; n_cs = 0; busy_hi = 0; done_busy = 1'b0;
        @(negedge clk);
        start = 1'b1; mode = m; base_addr = AW'(b); length = (AW + 1)'(n); seed = s;
        @(negedge clk);
        start = 1'b0; mode = 1'($urandom); base_addr = AW'($urandom); seed = $urandom;
        length = (AW + 1)'($urandom_range(1, 50));
        c = 1;
        while (c <= n + 10) begin
            start = (c == stray);
            if (mem_chipselect) begin
                n_cs++;
                if (mem_write) begin
                    q_waddr.push_back(int'(mem_address));
                    q_wdata.push_back(mem_writedata);
                    q_wcyc.push_back(c);
                end else begin
                    q_raddr.push_back(int'(mem_address));
                    q_rcyc.push_back(c);
                end
            end
            if (busy) busy_hi++;
            if (done) begin
                lat = c;
                done_busy = busy;
                break;
            end
            @(negedge clk);
            c++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({busy, done, mem_chipselect, mem_write, mem_clken} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00001", {busy, done, mem_chipselect, mem_write, mem_clken});
        end
        n_cmp++;
        if (mem_address !== '0 || mem_writedata !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: got addr %0h data %0h expected 0 0", mem_address, mem_writedata);
        end
        n_cmp++;
        if (err_count !== '0 || first_err_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_status: got err %0d first %0h expected 0 0", err_count, first_err_addr);
        end
        n_cmp++;
        if (mem_byteenable !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_be: got %b expected 1111", mem_byteenable);
        end
    endtask

    task automatic test_full_range();
        int bad;
        logic [DW-1:0] s;
        s = 32'h12345678;
        do_run(1'b0, 0, DEPTH, s, -1);
        n_cmp++;
        if (lat !== DEPTH + 1) begin
            n_fail++; $display("FAIL full_fill_latency: got %0d expected %0d", lat, DEPTH + 1);
        end
        n_cmp++;
        if (q_waddr.size() !== DEPTH || busy_hi !== DEPTH || done_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_fill_counts: got writes %0d busy %0d busy@done %b expected %0d %0d 0",
                     q_waddr.size(), busy_hi, done_busy, DEPTH, DEPTH);
        end
        bad = 0;
        for (int i = 0; i < q_waddr.size(); i++)
            if (q_waddr[i] != wa(0, i) || q_wdata[i] !== pat(s, i) || q_wcyc[i] != i + 1) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_fail++; $display("FAIL full_fill_words: got %0d bad words expected 0", bad);
        end
        do_run(1'b1, 0, DEPTH, s, -1);
        n_cmp++;
        if (lat !== DEPTH + 2 || busy_hi !== DEPTH + 1) begin
            n_fail++;
            $display("FAIL full_verify_latency: got done %0d busy %0d expected %0d %0d",
                     lat, busy_hi, DEPTH + 2, DEPTH + 1);
        end
        bad = 0;
        for (int i = 0; i < q_raddr.size(); i++)
            if (q_raddr[i] != wa(0, i) || q_rcyc[i] != i + 1) bad++;
        n_cmp++;
        if (q_raddr.size() !== DEPTH || bad != 0 || q_waddr.size() != 0) begin
            n_fail++;
            $display("FAIL full_verify_reads: got reads %0d bad %0d writes %0d expected %0d 0 0",
                     q_raddr.size(), bad, q_waddr.size(), DEPTH);
        end
        n_cmp++;
        if (err_count !== '0) begin
            n_fail++; $display("FAIL full_verify_err: got %0d expected 0", err_count);
        end
    endtask

    task automatic test_wrap();
        int bad;
        logic [DW-1:0] s;
        s = $urandom;
        do_run(1'b0, 'h3F0, 32, s, -1);
        bad = 0;
        for (int i = 0; i < q_waddr.size(); i++)
            if (q_waddr[i] != wa('h3F0, i) || q_wdata[i] !== pat(s, i)) bad++;
        n_cmp++;
        if (lat !== 33 || q_waddr.size() !== 32 || bad != 0) begin
            n_fail++;
            $display("FAIL wrap_fill: got done %0d writes %0d bad %0d expected 33 32 0",
                     lat, q_waddr.size(), bad);
        end
        do_run(1'b1, 'h3F0, 32, s, -1);
        n_cmp++;
        if (lat !== 34 || err_count !== '0) begin
            n_fail++;
            $display("FAIL wrap_verify: got done %0d err %0d expected 34 0", lat, err_count);
        end
    endtask

    task automatic test_mismatch();
        do_run(1'b0, 5, 4, 32'd0, -1);
        do_run(1'b1, 5, 4, 32'd1, -1);
        n_cmp++;
        if (lat !== 6 || err_count !== 4'd4 || first_err_addr !== 10'd5) begin
            n_fail++;
            $display("FAIL mismatch: got done %0d err %0d first %0d expected 6 4 5",
                     lat, err_count, first_err_addr);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (err_count !== 4'd4 || first_err_addr !== 10'd5) begin
            n_fail++;
            $display("FAIL result_hold: got err %0d first %0d expected 4 5", err_count, first_err_addr);
        end
    endtask

    task automatic test_saturation();
        int b;
        logic [DW-1:0] s;
        b = $urandom_range(0, DEPTH - 1);
        s = $urandom;
        do_run(1'b0, b, 20, s, -1);
        do_run(1'b1, b, 20, s + 32'($urandom_range(1, 1000)), -1);
        n_cmp++;
        if (err_count !== 4'(EMAX) || first_err_addr !== AW'(b)) begin
            n_fail++;
            $display("FAIL saturation: got err %0d first %0d expected %0d %0d",
                     err_count, first_err_addr, EMAX, b);
        end
    endtask

    task automatic test_zero_len();
        do_run(1'b1, $urandom_range(0, DEPTH - 1), 0, $urandom, -1);
        n_cmp++;
        if (lat !== 1 || n_cs !== 0 || err_count !== '0 || first_err_addr !== '0) begin
            n_fail++;
            $display("FAIL zero_len: got done %0d cs %0d err %0d first %0d expected 1 0 0 0",
                     lat, n_cs, err_count, first_err_addr);
        end
    endtask

    task automatic test_random();
        int b, n, k, e, fa;
        logic [DW-1:0] s, vs;
        for (int it = 0; it < 6; it++) begin
            b = $urandom_range(0, DEPTH - 1);
            n = $urandom_range(1, 64);
            s = $urandom;
            do_run(1'b0, b, n, s, -1);
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++)
                corrupt(wa(b, $urandom_range(0, n - 1)), 32'(1) << $urandom_range(0, DW - 1));
            vs = ($urandom_range(0, 3) == 0) ? s ^ 32'($urandom_range(1, 255)) : s;
            model_verify(b, n, vs, e, fa);
            do_run(1'b1, b, n, vs, -1);
            n_cmp++;
            if (lat !== n + 2 || q_raddr.size() !== n || err_count !== EW'(e)
                || first_err_addr !== AW'(fa)) begin
                n_fail++;
                $display("FAIL random_verify[%0d]: got done %0d reads %0d err %0d first %0d expected %0d %0d %0d %0d",
                         it, lat, q_raddr.size(), err_count, first_err_addr, n + 2, n, e, fa);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int b, bad;
        logic [DW-1:0] s;
        b = $urandom_range(0, DEPTH - 1);
        s = $urandom;
        do_run(1'b0, b, 20, s, 7);
        bad = 0;
        for (int i = 0; i < q_waddr.size(); i++)
            if (q_waddr[i] != wa(b, i) || q_wdata[i] !== pat(s, i)) bad++;
        n_cmp++;
        if (lat !== 21 || q_waddr.size() !== 20 || bad != 0) begin
            n_fail++;
            $display("FAIL busy_ignore: got done %0d writes %0d bad %0d expected 21 20 0",
                     lat, q_waddr.size(), bad);
        end
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (mem_chipselect || busy) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++; $display("FAIL busy_ignore_idle: got %0d active cycles expected 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        int b;
        logic [DW-1:0] s;
        b = $urandom_range(0, DEPTH - 1);
        s = $urandom;
        do_run(1'b0, b, 3, s, -1);
        do_run(1'b1, b, 3, s, -1);
        n_cmp++;
        if (lat !== 5 || q_raddr.size() !== 3 || err_count !== '0) begin
            n_fail++;
            $display("FAIL back_to_back: got done %0d reads %0d err %0d expected 5 3 0",
                     lat, q_raddr.size(), err_count);
        end
    endtask

    task automatic test_reset_abort();
        int seen_done, bad;
        logic [DW-1:0] s;
        logic cs_before;
        s = $urandom;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; base_addr = '0; length = 11'd100; seed = s;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        cs_before = mem_chipselect;
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (cs_before !== 1'b1 || mem_chipselect !== 1'b0 || mem_write !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_async: got cs_before %b cs %b we %b busy %b expected 1 0 0 0",
                     cs_before, mem_chipselect, mem_write, busy);
        end
        seen_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done || mem_chipselect) seen_done++;
        end
        n_cmp++;
        if (seen_done != 0) begin
            n_fail++; $display("FAIL abort_no_done: got %0d active cycles expected 0", seen_done);
        end
        do_run(1'b0, 40, 2, s, -1);
        bad = 0;
        for (int i = 0; i < q_waddr.size(); i++)
            if (q_waddr[i] != wa(40, i) || q_wdata[i] !== pat(s, i)) bad++;
        n_cmp++;
        if (lat !== 3 || q_waddr.size() !== 2 || bad != 0) begin
            n_fail++;
            $display("FAIL abort_rerun: got done %0d writes %0d bad %0d expected 3 2 0",
                     lat, q_waddr.size(), bad);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; base_addr = '0; length = '0; seed = '0;
        corr_req = 1'b0; corr_addr = '0; corr_mask = '0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_full_range();
        test_wrap();
        test_mismatch();
        test_saturation();
        test_zero_len();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
